// File: rtl/coef_threshold_stream.sv
// Streaming hard/soft coefficient thresholder between the DCT and the RLE encoder.
// The threshold and mode are frame-synchronous; each completed frame reports its non-zero count.
module coef_threshold_stream #(
  parameter int WIDTH     = 11,
  parameter int FRAME_LEN = 64,
  parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_data,
  input  logic                    mode,
  input  logic                    thr_load,
  input  logic [WIDTH-2:0]        thr_value,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_last,
  output logic                    out_zero,
  output logic [CNT_W-1:0]        nz_count,
  output logic                    nz_valid
);

  // Handshake: a transfer happens on any rising edge where valid && ready;
  // in_ready = !out_valid || out_ready, so the output stage refills in the
  // same cycle it drains and never stalls a continuous stream.

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH:0]   EXT_ONE  = (WIDTH + 1)'(1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   pos_q, pos_d;
  logic [CNT_W-1:0]   nz_run_q, nz_run_d;
  logic [CNT_W-1:0]   nz_count_q, nz_count_d;
  logic               nz_valid_q, nz_valid_d;
  logic [WIDTH-2:0]   thr_shadow_q, thr_shadow_d;
  logic [WIDTH-2:0]   t_act_q, t_act_d;
  logic               mode_act_q, mode_act_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               out_last_q, out_last_d;
  logic               out_zero_q, out_zero_d;

  logic               in_fire, out_fire, frame_start;
  logic [WIDTH-2:0]   t_use;
  logic               mode_use, neg;
  logic [WIDTH:0]     x_ext, abs_x, thr_ext;
  logic [WIDTH-1:0]   result;
  logic [CNT_W-1:0]   nz_next;

  always_comb begin
    in_ready    = !out_valid_q || out_ready;
    in_fire     = in_valid && in_ready;
    out_fire    = out_valid_q && out_ready;
    frame_start = in_fire && (state_q == IDLE);

    // A load in the same cycle as the first coefficient must already apply to it.
    t_use    = frame_start ? (thr_load ? thr_value : thr_shadow_q) : t_act_q;
    mode_use = frame_start ? mode : mode_act_q;

    neg     = in_data[WIDTH-1];
    x_ext   = {in_data[WIDTH-1], in_data};
    abs_x   = neg ? (~x_ext + EXT_ONE) : x_ext;
    thr_ext = {2'b00, t_use};

    // Outside the band |x| > T, so x +/- T cannot overflow WIDTH bits.
    result = '0;
    if (abs_x > thr_ext) begin
      if (!mode_use)  result = in_data;
      else if (neg)   result = in_data + {1'b0, t_use};
      else            result = in_data - {1'b0, t_use};
    end

    state_d      = state_q;
    pos_d        = pos_q;
    thr_shadow_d = thr_load ? thr_value : thr_shadow_q;
    t_act_d      = t_act_q;
    mode_act_d   = mode_act_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    out_zero_d   = out_zero_q;

    if (in_fire) begin
      if (frame_start) begin
        t_act_d    = t_use;
        mode_act_d = mode_use;
      end
      out_valid_d = 1'b1;
      out_data_d  = result;
      out_zero_d  = (result == '0);
      out_last_d  = (pos_q == LAST_POS);
      if (pos_q == LAST_POS) begin
        pos_d   = '0;
        state_d = IDLE;
      end else begin
        pos_d   = pos_q + CNT_ONE;
        state_d = RUN;
      end
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end

    // Counting on the output side keeps a new frame's first acceptance independent
    // of the old frame's closing transfer.
    nz_next    = nz_run_q + {{(CNT_W-1){1'b0}}, ~out_zero_q};
    nz_run_d   = nz_run_q;
    nz_count_d = nz_count_q;
    nz_valid_d = 1'b0;
    if (out_fire) begin
      if (out_last_q) begin
        nz_count_d = nz_next;
        nz_valid_d = 1'b1;
        nz_run_d   = '0;
      end else begin
        nz_run_d   = nz_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pos_q        <= '0;
      nz_run_q     <= '0;
      nz_count_q   <= '0;
      nz_valid_q   <= 1'b0;
      thr_shadow_q <= '0;
      t_act_q      <= '0;
      mode_act_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      out_zero_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      nz_run_q     <= nz_run_d;
      nz_count_q   <= nz_count_d;
      nz_valid_q   <= nz_valid_d;
      thr_shadow_q <= thr_shadow_d;
      t_act_q      <= t_act_d;
      mode_act_q   <= mode_act_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      out_zero_q   <= out_zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_zero  = out_zero_q;
  assign nz_count  = nz_count_q;
  assign nz_valid  = nz_valid_q;

endmodule

// File: tb/tb_coef_threshold_stream.sv
// Bench for coef_threshold_stream: directed scenario tasks plus a negedge scoreboard
// fed by an arithmetic reference model of thresholding, framing and counting.
module tb_coef_threshold_stream;

  localparam int W  = 11;
  localparam int FL = 64;
  localparam int CW = $clog2(FL + 1);

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          mode;
  logic          thr_load;
  logic [W-2:0]  thr_value;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_last;
  logic          out_zero;
  logic [CW-1:0] nz_count;
  logic          nz_valid;

  coef_threshold_stream #(.WIDTH(W), .FRAME_LEN(FL)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mode(mode), .thr_load(thr_load), .thr_value(thr_value),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_zero(out_zero),
    .nz_count(nz_count), .nz_valid(nz_valid)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model / scoreboard ----------------
  logic [W+1:0] exp_q[$];  // {data, last, zero}
  int   m_pos, m_shadow, m_tact, m_mode, m_run;
  logic exp_nzv;
  int   exp_nzc;
  logic stalled;
  logic [W+1:0] held;
  int   nzv_pulses = 0;
  bit   bp_en = 0;

  function automatic logic signed [W-1:0] ref_thr(input int x, input int t, input int md);
    int a;
    a = (x < 0) ? -x : x;
    if (a <= t) return '0;
    if (md == 0) return W'(x);
    return (x < 0) ? W'(-(a - t)) : W'(a - t);
  endfunction

  task automatic model_clear();
    exp_q.delete();
    m_pos = 0; m_shadow = 0; m_tact = 0; m_mode = 0; m_run = 0;
    exp_nzv = 1'b0; exp_nzc = 0; stalled = 1'b0; held = '0;
  endtask

  always @(negedge clk) begin
    logic [W+1:0] e, got;
    logic signed [W-1:0] r;
    int x, tn, inc;
    if (rst_n) begin
      checks++;
      if (nz_valid !== exp_nzv) begin
        errors++;
        $display("FAIL nz_valid t=%0t: got %b expected %b", $time, nz_valid, exp_nzv);
      end
      if (exp_nzv) begin
        checks++;
        if (nz_count !== CW'(exp_nzc)) begin
          errors++;
          $display("FAIL nz_count t=%0t: got %0d expected %0d", $time, nz_count, exp_nzc);
        end
      end
      exp_nzv = 1'b0;
      if (nz_valid === 1'b1) nzv_pulses++;

      checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        errors++;
        $display("FAIL in_ready t=%0t: got %b expected %b", $time, in_ready, (!out_valid || out_ready));
      end

      if (stalled) begin
        checks++;
        if ({out_valid, out_data, out_last, out_zero} !== {1'b1, held}) begin
          errors++;
          $display("FAIL stall_hold t=%0t: got v=%b %h expected v=1 %h", $time, out_valid,
                   {out_data, out_last, out_zero}, held);
        end
      end

      checks++;
      if (out_valid !== (exp_q.size() != 0)) begin
        errors++;
        $display("FAIL out_valid t=%0t: got %b expected %b", $time, out_valid, (exp_q.size() != 0));
      end

      if (out_valid && out_ready && exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {out_data, out_last, out_zero};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL out_sample t=%0t: got data=%0d last=%b zero=%b expected data=%0d last=%b zero=%b",
                   $time, $signed(out_data), out_last, out_zero, $signed(e[W+1:2]), e[1], e[0]);
        end
        inc = e[0] ? 0 : 1;
        if (e[1]) begin
          exp_nzv = 1'b1;
          exp_nzc = m_run + inc;
          m_run   = 0;
        end else begin
          m_run = m_run + inc;
        end
      end

      stalled = out_valid && !out_ready;
      held    = {out_data, out_last, out_zero};

      if (in_valid && in_ready) begin
        tn = thr_load ? int'(thr_value) : m_shadow;
        if (m_pos == 0) begin
          m_tact = tn;
          m_mode = int'(mode);
        end
        x = int'($signed(in_data));
        r = ref_thr(x, m_tact, m_mode);
        exp_q.push_back({r, (m_pos == FL - 1), (r == 0)});
        m_pos = (m_pos + 1) % FL;
      end
      if (thr_load) m_shadow = int'(thr_value);
    end
  end

  // ---------------- drivers ----------------
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send(input int x, input bit ld = 0, input int v = 0);
    int   n;
    logic ok;
    in_valid = 1'b1;
    in_data  = W'(x);
    if (ld) begin
      thr_load  = 1'b1;
      thr_value = (W-1)'(v);
    end
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 1000) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      n++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed %b, expected 1 within 1000 cycles", in_ready);
    end
    #1;
    thr_load = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_thr(input int v, input bit md);
    in_valid  = 1'b0;
    thr_value = (W-1)'(v);
    mode      = md;
    thr_load  = 1'b1;
    @(posedge clk);
    #1;
    thr_load  = 1'b0;
  endtask

  task automatic assert_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    in_valid = 1'b0;
    thr_load = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    assert_reset();
    release_reset();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [W+CW+3:0] snap;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; mode = 1'b0; thr_load = 1'b0; thr_value = '0;
    model_clear();
    #12;
    snap = {out_valid, out_data, out_last, out_zero, nz_count, nz_valid};
    checks++;
    if (snap !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got outputs=%h in_ready=%b expected 0 and 1", snap, in_ready);
    end
    release_reset();
  endtask

  task automatic test_hard();
    int v[6] = '{3, -3, 4, -4, -1024, 1023};
    int e[6] = '{0, 0, 4, -4, -1024, 1023};
    logic z[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [W-1:0] ev;
    do_reset();
    set_thr(3, 1'b0);
    for (int i = 0; i < 6; i++) begin
      send(v[i]);
      ev = W'(e[i]);
      checks++;
      if (out_valid !== 1'b1 || out_data !== ev || out_zero !== z[i]) begin
        errors++;
        $display("FAIL hard_%0d: got v=%b data=%0d zero=%b expected v=1 data=%0d zero=%b",
                 i, out_valid, $signed(out_data), out_zero, e[i], z[i]);
      end
    end
    idle(3);
  endtask

  task automatic test_soft();
    int v[5] = '{5, -5, 3, -1024, 0};
    int e[5] = '{2, -2, 0, -1021, 0};
    logic [W-1:0] ev;
    do_reset();
    set_thr(3, 1'b1);
    for (int i = 0; i < 5; i++) begin
      send(v[i]);
      ev = W'(e[i]);
      checks++;
      if (out_data !== ev || out_zero !== (e[i] == 0)) begin
        errors++;
        $display("FAIL soft_%0d: got data=%0d zero=%b expected data=%0d zero=%b",
                 i, $signed(out_data), out_zero, e[i], (e[i] == 0));
      end
    end
    idle(3);
  endtask

  task automatic test_frame();
    int p0;
    do_reset();
    set_thr(10, 1'b0);
    p0 = nzv_pulses;
    for (int k = 0; k < FL; k++) begin
      send(k - 32);
      checks++;
      if (out_last !== (k == FL - 1)) begin
        errors++;
        $display("FAIL frame_last_%0d: got %b expected %b", k, out_last, (k == FL - 1));
      end
    end
    for (int k = 0; k < FL; k++) begin
      send(int'($urandom_range(0, 2047)) - 1024);
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL frame_gap_%0d: got out_valid %b expected 1", k, out_valid);
      end
      if (k == 0) begin
        checks++;
        if (nz_valid !== 1'b1 || nz_count !== CW'(43)) begin
          errors++;
          $display("FAIL frame_count: got nz_valid=%b nz_count=%0d expected 1 and 43", nz_valid, nz_count);
        end
      end
    end
    idle(4);
    checks++;
    if (nzv_pulses - p0 !== 2) begin
      errors++;
      $display("FAIL frame_pulses: got %0d expected 2", nzv_pulses - p0);
    end
  endtask

  task automatic test_thr_update();
    int x;
    logic [W-1:0] ev;
    do_reset();
    set_thr(3, 1'b0);
    for (int k = 0; k < FL; k++) begin
      x = (k % 2) ? 3 : -3;
      send(x, (k == 30), 0);
      if (k > 30) begin
        checks++;
        if (out_data !== '0) begin
          errors++;
          $display("FAIL thr_old_%0d: got %0d expected 0", k, $signed(out_data));
        end
      end
    end
    for (int k = 0; k < FL; k++) begin
      x  = (k % 2) ? 3 : -3;
      ev = W'(x);
      send(x);
      checks++;
      if (out_data !== ev) begin
        errors++;
        $display("FAIL thr_new_%0d: got %0d expected %0d", k, $signed(out_data), x);
      end
    end
    send(5, 1'b1, 5);
    checks++;
    if (out_data !== '0 || out_zero !== 1'b1) begin
      errors++;
      $display("FAIL thr_coincident: got data=%0d zero=%b expected 0 and 1", $signed(out_data), out_zero);
    end
    idle(3);
  endtask

  task automatic test_backpressure();
    int p0;
    do_reset();
    set_thr(int'($urandom_range(0, 40)), 1'($urandom_range(0, 1)));
    p0 = nzv_pulses;
    bp_en = 1;
    for (int k = 0; k < 2 * FL + 10; k++)
      send(int'($urandom_range(0, 2047)) - 1024, ($urandom_range(0, 15) == 0),
           int'($urandom_range(0, 60)));
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    bp_en = 0;
    idle(5);
    checks++;
    if (exp_q.size() != 0 || nzv_pulses - p0 != 2) begin
      errors++;
      $display("FAIL bp_drain: got pending=%0d pulses=%0d expected 0 and 2", exp_q.size(), nzv_pulses - p0);
    end
  endtask

  task automatic test_reset_mid();
    logic [W+CW+3:0] snap;
    int p0;
    logic [W-1:0] ev;
    do_reset();
    set_thr(5, 1'b1);
    for (int k = 0; k < 20; k++) send(int'($urandom_range(0, 2047)) - 1024);
    p0 = nzv_pulses;
    #2;
    rst_n = 1'b0;
    #1;
    snap = {out_valid, out_data, out_last, out_zero, nz_count, nz_valid};
    checks++;
    if (snap !== '0) begin
      errors++;
      $display("FAIL reset_mid_async: got outputs=%h expected 0", snap);
    end
    mode = 1'b0;
    release_reset();
    ev = W'(-3);
    send(-3);
    checks++;
    if (out_data !== ev || out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_first: got data=%0d last=%b expected -3 and 0", $signed(out_data), out_last);
    end
    for (int k = 1; k < FL; k++) send(int'($urandom_range(0, 2047)) - 1024);
    idle(4);
    checks++;
    if (nzv_pulses - p0 != 1) begin
      errors++;
      $display("FAIL reset_mid_pulses: got %0d expected 1", nzv_pulses - p0);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_hard();
    test_soft();
    test_frame();
    test_thr_update();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    checks++;
    errors++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
